// File: rtl/camera_pkg.sv
// Shared definitions for the camera readout path.
// Provides default geometry, the read-side state encoding and a helper that
// sizes the pixel index counter. No ports: imported by the other rtl files.
package camera_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_COLS = 2;
    localparam int N_ROWS     = 2;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // Ceiling log2, never less than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    // Width of the index that walks every pixel of one frame.
    function automatic int pix_idx_w(input int n_cols);
        return clog2(N_ROWS * n_cols);
    endfunction
endpackage

// File: rtl/readout_buffer_if.sv
// Pixel stream towards the off-chip link.
//   out_data  : pixel value
//   out_valid : out_data/out_first/out_last are meaningful
//   out_ready : sink accepts the pixel
//   out_first : pixel is row 0, column 0
//   out_last  : pixel is row 1, last column
// Handshake: a pixel transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid is raised the master holds data,
// first and last unchanged until the transfer happens; out_ready may
// change freely and has no combinational path to out_valid.
interface readout_buffer_if #(
    parameter int DATA_W = camera_pkg::DEF_DATA_W
) ();
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/readout_bank.sv
// Ping-pong frame store: 2 banks x N_ROWS rows x N_COLS words.
//   clk        : clock
//   i_wr_en    : write one full row this cycle
//   i_wr_bank  : bank to write
//   i_wr_row   : row to write
//   i_wr_data  : N_COLS words, column c at [c*DATA_W +: DATA_W]
//   i_rd_bank  : bank to read
//   i_rd_idx   : pixel index inside the frame (row*N_COLS + col)
//   o_rd_data  : combinational read of that pixel
module readout_bank
    import camera_pkg::*;
#(
    parameter int N_COLS = DEF_N_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = pix_idx_w(DEF_N_COLS)
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic                     i_wr_bank,
    input  logic                     i_wr_row,
    input  logic [N_COLS*DATA_W-1:0] i_wr_data,
    input  logic                     i_rd_bank,
    input  logic [IDX_W-1:0]         i_rd_idx,
    output logic [DATA_W-1:0]        o_rd_data
);
    localparam int DEPTH = 2 * N_ROWS * N_COLS;
    localparam int AW    = clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     w_wr_base;
    logic [AW-1:0]     w_rd_addr;

    assign w_wr_base = AW'(i_wr_bank) * AW'(N_ROWS * N_COLS) + AW'(i_wr_row) * AW'(N_COLS);
    assign w_rd_addr = AW'(i_rd_bank) * AW'(N_ROWS * N_COLS) + AW'(i_rd_idx);

    // Storage carries no reset: bank occupancy is tracked by the top level.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int c = 0; c < N_COLS; c++) begin
                r_mem[w_wr_base + AW'(c)] <= i_wr_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign o_rd_data = r_mem[w_rd_addr];
endmodule

// File: rtl/readout_buffer.sv
// Readout buffer between the exposure/readout controller and the link.
// Captures one row of column ADC words per adc rising edge into a ping-pong
// frame store and streams complete 2-row frames pixel by pixel.
//   clk, reset  : clock, synchronous active-high reset
//   nre1, nre2  : active-low row strobes (exactly one low selects the row)
//   adc         : capture strobe, one capture per high pulse
//   erase       : discards the partially captured frame
//   col_data    : column words, column c at [c*DATA_W +: DATA_W]
//   out_if      : pixel stream (master side)
//   overflow    : one-cycle pulse, completed frame dropped (no free bank)
//   row_error   : one-cycle pulse, illegal or duplicate row strobe
//   frame_count : frames fully delivered, wraps
//   rd_state    : read FSM state, for observation
module readout_buffer
    import camera_pkg::*;
#(
    parameter int N_COLS = DEF_N_COLS,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     nre1,
    input  logic                     nre2,
    input  logic                     adc,
    input  logic                     erase,
    input  logic [N_COLS*DATA_W-1:0] col_data,
    readout_buffer_if.master         out_if,
    output logic                     overflow,
    output logic                     row_error,
    output logic [7:0]               frame_count,
    output rd_state_t                rd_state
);
    localparam int                IDX_W    = pix_idx_w(N_COLS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ROWS * N_COLS - 1);

    logic             r_adc_d;
    logic [1:0]       r_mask;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_full;
    rd_state_t        r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_overflow;
    logic             r_row_error;
    logic [7:0]       r_frame_count;

    logic              w_cap;
    logic              w_row_ok;
    logic              w_row;
    logic              w_capture_ok;
    logic [1:0]        w_mask_set;
    logic              w_complete;
    logic              w_valid;
    logic              w_accept;
    logic              w_free;
    logic              w_bank_avail;
    logic              w_wr_en;
    logic [1:0]        w_full_next;
    rd_state_t         w_state_next;
    logic [IDX_W-1:0]  w_idx_next;
    logic [DATA_W-1:0] w_rd_data;

    assign w_cap        = adc && !r_adc_d;
    assign w_row_ok     = nre1 ^ nre2;
    assign w_row        = nre1;               // nre1 high with nre2 low selects row 1
    assign w_capture_ok = w_cap && !erase && w_row_ok;
    assign w_mask_set   = r_mask | (2'b01 << w_row);
    assign w_complete   = w_capture_ok && (w_mask_set == 2'b11);

    assign w_valid  = (r_state == RD_STREAM);
    assign w_accept = w_valid && out_if.out_ready;
    assign w_free   = w_accept && (r_idx == LAST_IDX);

    // The write bank is usable if empty or released by the reader this edge.
    // Rows aimed at a bank still being read are not stored, so an overflowing
    // frame never corrupts the frame being streamed.
    assign w_bank_avail = !r_full[r_wr_bank] || (w_free && (r_rd_bank == r_wr_bank));
    assign w_wr_en      = w_capture_ok && w_bank_avail;

    always_comb begin
        w_full_next = r_full;
        if (w_free) w_full_next[r_rd_bank] = 1'b0;
        if (w_complete && w_bank_avail) w_full_next[r_wr_bank] = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_next = RD_STREAM;
                    w_idx_next   = '0;
                end
            end
            RD_STREAM: begin
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = r_full[~r_rd_bank] ? RD_STREAM : RD_IDLE;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adc_d       <= 1'b0;
            r_mask        <= 2'b00;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_full        <= 2'b00;
            r_state       <= RD_IDLE;
            r_idx         <= '0;
            r_overflow    <= 1'b0;
            r_row_error   <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_adc_d <= adc;
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_full  <= w_full_next;
            if (w_free) begin
                r_rd_bank     <= ~r_rd_bank;
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (erase || w_complete) r_mask <= 2'b00;
            else if (w_capture_ok)   r_mask <= w_mask_set;
            if (w_complete && w_bank_avail) r_wr_bank <= ~r_wr_bank;
            r_overflow  <= w_complete && !w_bank_avail;
            r_row_error <= w_cap && !erase && (!w_row_ok || r_mask[w_row]);
        end
    end

    readout_bank #(
        .N_COLS (N_COLS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (r_wr_bank),
        .i_wr_row  (w_row),
        .i_wr_data (col_data),
        .i_rd_bank (r_rd_bank),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_rd_data)
    );

    assign out_if.out_valid = w_valid;
    assign out_if.out_data  = w_valid ? w_rd_data : '0;
    assign out_if.out_first = w_valid && (r_idx == '0);
    assign out_if.out_last  = w_valid && (r_idx == LAST_IDX);
    assign overflow         = r_overflow;
    assign row_error        = r_row_error;
    assign frame_count      = r_frame_count;
    assign rd_state         = r_state;
endmodule
